// File: rtl/gb_mem_map.sv
// Shared Game Boy memory-map constants and the OAM DMA state encoding.
package gb_mem_map;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_LEN      = 160;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    READ  = 3'd2,
    LATCH = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and mmu-side bus bundle for the OAM DMA bus master / mux.
interface oam_dma_if;

  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  oCpuData;
  logic        oCpuWait;
  logic        oDmaActive;
  logic [15:0] oMmuAddr;
  logic        oMmuWe;
  logic [7:0]  oMmuData;
  logic [7:0]  iMmuData;

  // The DMA block itself.
  modport slave (
    input  iCpuAddr, iCpuWe, iCpuData, iMmuData,
    output oCpuData, oCpuWait, oDmaActive, oMmuAddr, oMmuWe, oMmuData
  );

  // The surrounding CPU core and mmu.
  modport master (
    output iCpuAddr, iCpuWe, iCpuData, iMmuData,
    input  oCpuData, oCpuWait, oDmaActive, oMmuAddr, oMmuWe, oMmuData
  );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: owns FF46, copies 160 bytes from {src,00} to FE00..FE9F while
// stalling the CPU, otherwise passes CPU traffic straight through to the mmu.
module oam_dma
  import gb_mem_map::*;
(
  input logic      iClock,
  input logic      iReset,
  oam_dma_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_e state;
  logic [7:0] rDmaSrc;
  logic [7:0] rIdx;
  logic [7:0] rByte;
  logic       rRegRd;
  logic       rBusy;
  logic       cpuRegWr;

  assign cpuRegWr = bus.iCpuWe && (bus.iCpuAddr == DMA_REG_ADDR);

  // rBusy mirrors (state != IDLE) so the stall outputs come straight from a flop.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= IDLE;
      rDmaSrc <= 8'h00;
      rIdx    <= 8'h00;
      rByte   <= 8'h00;
      rRegRd  <= 1'b0;
      rBusy   <= 1'b0;
    end else begin
      rRegRd <= (bus.iCpuAddr == DMA_REG_ADDR);
      case (state)
        IDLE: begin
          if (cpuRegWr) begin
            rDmaSrc <= bus.iCpuData;
            rIdx    <= 8'h00;
            rBusy   <= 1'b1;
            state   <= START;
          end
        end
        START: state <= READ;
        READ:  state <= LATCH;
        LATCH: begin
          rByte <= bus.iMmuData;
          state <= WRITE;
        end
        WRITE: begin
          if (rIdx == LAST_IDX) begin
            rBusy <= 1'b0;
            state <= IDLE;
          end else begin
            rIdx  <= rIdx + 8'h01;
            state <= READ;
          end
        end
        default: begin
          rBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus mux: mmu read data arrives one cycle after the address, so the
  // register-read select is delayed by one cycle to line up with it.
  always_comb begin
    bus.oMmuAddr = bus.iCpuAddr;
    bus.oMmuData = bus.iCpuData;
    bus.oMmuWe   = bus.iCpuWe && (bus.iCpuAddr != DMA_REG_ADDR);
    bus.oCpuData = rRegRd ? rDmaSrc : bus.iMmuData;
    case (state)
      IDLE: ;
      WRITE: begin
        bus.oMmuAddr = OAM_BASE + {8'h00, rIdx};
        bus.oMmuData = rByte;
        bus.oMmuWe   = 1'b1;
        bus.oCpuData = 8'hFF;
      end
      default: begin
        bus.oMmuAddr = {rDmaSrc, rIdx};
        bus.oMmuData = rByte;
        bus.oMmuWe   = 1'b0;
        bus.oCpuData = 8'hFF;
      end
    endcase
  end

  assign bus.oCpuWait   = rBusy;
  assign bus.oDmaActive = rBusy;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus master and bus mux sitting directly upstream of mmu, between the CPU core and the mmu port (iAddr/iWe/iData/oData).
- Owns the DMA source register at 0xFF46. A CPU write to it copies 160 bytes from {src,8'h00} to OAM at 0xFE00–0xFE9F.
- While the copy runs, the block owns the mmu bus and stalls the CPU. Otherwise it passes CPU traffic straight through.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- OAM_BASE, 16'hFE00, destination base address.
- DMA_LEN, 160, bytes per transfer (counter width 8).

Ports:
- iClock  in  1  system clock; all state updates on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCpuAddr  in  16  CPU address.
- iCpuWe  in  1  CPU write strobe.
- iCpuData  in  8  CPU write data.
- oCpuData  out  8  read data returned to the CPU.
- oCpuWait  out  1  CPU must hold its current access while high.
- oDmaActive  out  1  transfer in progress (for PPU OAM lockout).
- oMmuAddr  out  16  to mmu iAddr.
- oMmuWe  out  1  to mmu iWe.
- oMmuData  out  8  to mmu iData.
- iMmuData  in  8  from mmu oData. Valid for the address presented in the previous cycle.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rDmaSrc=8'h00, rIdx=0, rByte=0, rRegRd=0.
  - oCpuWait=0, oDmaActive=0, oMmuWe=0.
  - Reset overrides any simultaneous CPU write.
- IDLE passthrough:
  - oMmuAddr=iCpuAddr, oMmuData=iCpuData.
  - oMmuWe=iCpuWe & (iCpuAddr!=DMA_REG_ADDR). FF46 writes never reach mmu.
- FF46 read:
  - rRegRd registers (iCpuAddr==DMA_REG_ADDR) each cycle.
  - oCpuData = rRegRd ? rDmaSrc : iMmuData. This matches mmu's one-cycle read latency.
- Trigger: in IDLE, iCpuWe && iCpuAddr==DMA_REG_ADDR at edge T.
  - rDmaSrc<=iCpuData, rIdx<=0, state<=START.
- State machine, 3 cycles per byte:
  - START: bus idle, oMmuWe=0. Go to READ.
  - READ: oMmuAddr={rDmaSrc,rIdx}, oMmuWe=0. Go to LATCH.
  - LATCH: hold the same address; rByte<=iMmuData at end of cycle. Go to WRITE.
  - WRITE: oMmuAddr=OAM_BASE+rIdx, oMmuData=rByte, oMmuWe=1.
    - If rIdx==DMA_LEN-1: go to IDLE.
    - Else: rIdx<=rIdx+1 and go to READ.
- Outputs outside IDLE:
  - oCpuWait=oDmaActive=1 in START/READ/LATCH/WRITE.
  - CPU inputs are ignored; oCpuData=8'hFF.
- Cycle counts:
  - Busy cycles T+1..T+481 (1+3×DMA_LEN).
  - oCpuWait low again at T+482, passthrough resumes in that cycle.
- Source address:
  - rDmaSrc is used unmodified, including 0x00–0x3F (BIOS/cartridge) and 0xE0–0xFF.
  - No clamping or echo folding.
- Address arithmetic:
  - Source low byte = rIdx (never exceeds 0x9F, no carry into the high byte).
  - OAM_BASE+rIdx is a 16-bit add.
- A write to FF46 in the same cycle the FSM returns to IDLE (T+482 onward) starts a new transfer normally.
- Reset mid-transfer: IDLE at the next edge. OAM bytes already written stay; remaining bytes are not written; oCpuWait drops immediately after reset.
- No second trigger can arrive during a transfer, because CPU inputs are ignored while busy.

Decomposition:
- Shared package gb_mem_map holds:
  - Constants DMA_REG_ADDR, OAM_BASE, OAM_LEN=160, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE.
  - State encoding localparams (IDLE/START/READ/LATCH/WRITE, 3-bit).
- No sub-module. FSM, index counter and bus mux live in one module.

Test Plan:
- Passthrough: with mmu model, CPU write 0x5A to 0x8010, then read 0x8010 -> oMmuWe=1 same cycle; oCpuData=0x5A one cycle after the read address; oCpuWait stays 0.
- Basic DMA: preload 0xC000+i = i^0xA5; write 0xC0 to FF46 at T -> oCpuWait high T+1..T+481; exactly 160 mmu writes, addresses 0xFE00..0xFE9F ascending, data i^0xA5; oCpuWait=0 at T+482.
- Register readback: after the transfer, read FF46 -> oCpuData=0xC0 one cycle later; mmu never sees We on 0xFF46.
- Reset mid-transfer: assert iReset during byte 50's LATCH -> next cycle state IDLE, oCpuWait=0; OAM 0xFE00..0xFE31 written, 0xFE32..0xFE9F unchanged.
- Back-to-back with BIOS source: write 0x00 to FF46, then on T+482 write 0x81 -> first copy uses addresses 0x0000..0x009F; second starts with START at T+483 and reads 0x8100 first.
- CPU activity during DMA: drive CPU write 0x33 to 0xC000 during busy -> no mmu write to 0xC000; oCpuData=0xFF.
